// File: rtl/muldiv_seq_if.sv
// EX-stage to multiply/divide sequencer request and HI/LO write-back bundle.
// master = pipeline side, slave = sequencer side.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             whi;
    logic             wlo;
    logic [WIDTH-1:0] wHiData;
    logic [WIDTH-1:0] wLoData;

    modport master (
        output start, op, opA, opB, cancel,
        input  busy, done, whi, wlo, wHiData, wLoData
    );

    modport slave (
        input  start, op, opA, opB, cancel,
        output busy, done, whi, wlo, wHiData, wLoData
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning all HI/LO writes.
// Define MULDIV_FASTZERO_EN to finish multiplies by a zero operand in one cycle.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_WB} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_r;
    logic               is_div, neg, rneg;

    logic               valid_op, accept, sgn, zero_b, fast, last;
    logic [WIDTH-1:0]   mag_a, mag_b, madd;
    logic [WIDTH:0]     msum, dtry;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;

    assign valid_op = !(bus.op[2] && bus.op[1]);
    assign accept   = (state == S_IDLE) && bus.start && !bus.cancel && valid_op;
    assign sgn      = !bus.op[2] && !bus.op[0];
    assign zero_b   = (bus.opB == '0);
    assign mag_a    = (sgn && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
    assign mag_b    = (sgn && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

`ifdef MULDIV_FASTZERO_EN
    assign fast = bus.op[2] || (bus.op[1] && zero_b)
                  || (!bus.op[1] && (zero_b || bus.opA == '0));
`else
    assign fast = bus.op[2] || (bus.op[1] && zero_b);
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Shift-add: multiplier sits in the low half and shifts out as the
    // product shifts in from the top.
    assign madd    = acc[0] ? b_r : '0;
    assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, madd};
    assign mul_nxt = {msum, acc[WIDTH-1:1]};

    // Restoring divide: {remainder, quotient/dividend} shifts left each step.
    assign dtry    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, b_r};
    assign div_nxt = dtry[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {dtry[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix = neg ? -acc : acc;
    assign q_fix    = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign fix_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];

    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_n = fast ? S_WB : (bus.op[1] ? S_DIV : S_MUL);
            end
            S_MUL, S_DIV: begin
                if (bus.cancel) state_n = S_IDLE;
                else if (last)  state_n = S_FIX;
            end
            S_FIX:   state_n = bus.cancel ? S_IDLE : S_WB;
            S_WB:    state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            b_r         <= '0;
            is_div      <= 1'b0;
            neg         <= 1'b0;
            rneg        <= 1'b0;
            bus.done    <= 1'b0;
            bus.whi     <= 1'b0;
            bus.wlo     <= 1'b0;
            bus.wHiData <= '0;
            bus.wLoData <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.whi  <= 1'b0;
            bus.wlo  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acc    <= {{WIDTH{1'b0}}, mag_a};
                        b_r    <= mag_b;
                        is_div <= bus.op[1];
                        neg    <= sgn && (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                        rneg   <= sgn && bus.opA[WIDTH-1];
                        if (fast) begin
                            bus.done <= 1'b1;
                            if (bus.op[2]) begin
                                bus.whi <= !bus.op[0];
                                bus.wlo <= bus.op[0];
                                if (bus.op[0]) bus.wLoData <= bus.opA;
                                else           bus.wHiData <= bus.opA;
                            end else if (bus.op[1]) begin
                                bus.whi     <= 1'b1;
                                bus.wlo     <= 1'b1;
                                bus.wHiData <= bus.opA;
                                bus.wLoData <= '1;
                            end else begin
                                bus.whi     <= 1'b1;
                                bus.wlo     <= 1'b1;
                                bus.wHiData <= '0;
                                bus.wLoData <= '0;
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (!bus.cancel) begin
                        bus.done    <= 1'b1;
                        bus.whi     <= 1'b1;
                        bus.wlo     <= 1'b1;
                        bus.wHiData <= fix_hi;
                        bus.wLoData <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer that owns every write port of the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and iterates one bit per cycle for mul/div.
- Drives the HI/LO write strobes and data in a single committing cycle.
- Raises busy so the pipeline stalls later HI/LO users (MFHI/MFLO, further mul/div).

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  op request valid, sampled in IDLE only
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x ignored
- opA  in  WIDTH  rs operand (multiplicand/dividend/MTxx source)
- opB  in  WIDTH  rt operand (multiplier/divisor)
- cancel  in  1  pipeline flush; aborts in-flight op
- busy  out  1  state != IDLE; stall request
- done  out  1  one-cycle pulse, coincident with the write strobes
- whi  out  1  HI write enable
- wlo  out  1  LO write enable
- wHiData  out  WIDTH  HI write data
- wLoData  out  WIDTH  LO write data

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, whi, wlo = 0; wHiData, wLoData, counter and accumulators = 0. An op in flight is discarded with no write.
- States: IDLE, MUL, DIV, FIX, WB. All outputs are registered or decoded from the state register only; there are no combinational input-to-output paths.
- Accept: IDLE & start & !cancel & valid op. Start is ignored when busy. Invalid op codes stay in IDLE.
- MTHI/MTLO: IDLE→WB.
  - Next cycle: whi (resp. wlo)=1, wHiData (resp. wLoData)=opA, done=1.
  - Latency 1.
- MULT/MULTU: IDLE→MUL.
  - Latch |opA|, |opB| for signed ops, or raw values for unsigned.
  - Record result sign = opA[31]^opB[31] (signed only).
  - MUL runs exactly WIDTH cycles of shift-add into a 2*WIDTH product register; counter counts 0..WIDTH-1.
  - Then FIX: two's-complement negate the 64-bit product if the sign flag is set.
  - Then WB: whi=wlo=1, {wHiData,wLoData} = product.
  - Latency start→WB = WIDTH+2 (34). The HI/LO register holds the result one cycle after WB.
- DIV/DIVU: IDLE→DIV with magnitudes as for MUL.
  - Restoring division, one quotient bit per cycle, WIDTH cycles.
  - FIX: negate quotient if signs differ; remainder takes the sign of the dividend.
  - WB: wLoData=quotient, wHiData=remainder.
  - Latency 34.
- Divide by zero (opB==0), detected at accept: IDLE→WB directly. wHiData=opA, wLoData=0xFFFFFFFF, for both DIV and DIVU. Latency 1.
- Overflow DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0. Results wrap; no exception.
- WB always returns to IDLE next cycle. done, whi and wlo are high for exactly one cycle.
- cancel:
  - In MUL/DIV/FIX: go to IDLE next cycle, no write, done=0.
  - In WB: ignored; the write commits.
  - In IDLE: blocks acceptance that cycle.
- start asserted in the WB cycle is not accepted. A new op is accepted the cycle after busy falls.

Optional Feature:
- Macro MULDIV_FASTZERO_EN.
- Defined: MULT/MULTU with opA==0 or opB==0 goes IDLE→WB, writing HI=LO=0 with latency 1.
- Undefined: zero operands take the full 34-cycle path; the result is identical.

Test Plan:
- MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> at cycle 34: whi=wlo=done=1, wHiData=0xFFFFFFFE, wLoData=0x00000001; busy high cycles 1..34.
- MULT opA=0xFFFFFFFD (-3), opB=5 -> wHiData=0xFFFFFFFF, wLoData=0xFFFFFFF1; then DIV opA=0xFFFFFFF9 (-7), opB=2 -> wLoData=0xFFFFFFFD, wHiData=0xFFFFFFFF.
- DIVU opA=0x12345678, opB=0 -> next cycle: wHiData=0x12345678, wLoData=0xFFFFFFFF, latency 1; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI opA=0xA5A5A5A5 -> next cycle whi=1, wlo=0, wHiData=0xA5A5A5A5; MTLO -> wlo only.
- MULTU 7×9, cancel at cycle 10 -> busy low at cycle 11, whi/wlo never asserted; start during busy ignored; rst pulse mid-DIV -> all outputs 0 immediately, no write.
- With MULDIV_FASTZERO_EN: MULT 0×0x1234 -> write HI=LO=0 at cycle 1. Without it -> same write at cycle 34.
